// File: rtl/alu_pkg.sv
// Opcode encodings and control-FSM state type shared by the multicycle ALU files.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_ADD   = 3'b010,
        OP_SRL   = 3'b011,
        OP_ADDIU = 3'b100,
        OP_MUL   = 3'b101,
        OP_SUB   = 3'b110,
        OP_SLT   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational datapath for the single-cycle opcodes: result, carry-out and signed overflow.
// Latency 0 (pure logic); no flow control. SRL yields a unshifted, MUL yields 0.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           sum_ovf;
    logic           diff_ovf;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = sum_ovf;
            end
            OP_ADDIU: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                cout     = diff[WIDTH];
                overflow = diff_ovf;
            end
            // Signed less-than: sign of a-b corrected by its overflow.
            OP_SLT:   result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ diff_ovf};
            OP_SRL:   result = a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: 1-cycle logic/arith ops, iterative SRL, shift-add MUL when MULTICYCLE_ALU_MUL_EN is defined.
// Latency 1 cycle; SRL shamt+1 (1 if shamt=0); MUL WIDTH+1.
// Result held in DONE until out_ready; a new op may be accepted in the handshake cycle.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         signal,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               overflow,
    output logic               zero,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic             accept;
    logic             start_iter;
    logic             last_iter;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_load;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opa_shift;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] core_result;
    logic             core_cout;
    logic             core_ovf;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ITER);
    assign last_iter = (cnt_q == CNT_W'(1));

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op       (op_t'(signal)),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .cout     (core_cout),
        .overflow (core_ovf)
    );

`ifdef MULTICYCLE_ALU_MUL_EN
    logic             mul_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;

    assign start_iter  = ((signal == OP_SRL) && (shamt != '0)) || (signal == OP_MUL);
    assign cnt_load    = (signal == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
    // opa is the shifted multiplicand for MUL, the shifted operand for SRL.
    assign acc_next    = acc_q + (opb_q[0] ? opa_q : '0);
    assign opa_shift   = mul_q ? (opa_q << 1) : (opa_q >> 1);
    assign iter_result = mul_q ? acc_next : opa_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q <= 1'b0;
            opb_q <= '0;
            acc_q <= '0;
        end else if (accept) begin
            mul_q <= (signal == OP_MUL);
            opb_q <= b;
            acc_q <= '0;
        end else if (state_q == ITER) begin
            opb_q <= opb_q >> 1;
            acc_q <= acc_next;
        end
    end
`else
    assign start_iter  = (signal == OP_SRL) && (shamt != '0);
    assign cnt_load    = CNT_W'(shamt);
    assign opa_shift   = opa_q >> 1;
    assign iter_result = opa_shift;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = start_iter ? ITER : DONE;
            ITER: if (last_iter) state_d = DONE;
            DONE: begin
                if (accept)         state_d = start_iter ? ITER : DONE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            opa_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            if (start_iter) begin
                opa_q <= a;
                cnt_q <= cnt_load;
            end else begin
                result   <= core_result;
                cout     <= core_cout;
                overflow <= core_ovf;
                zero     <= (core_result == '0);
            end
        end else if (state_q == ITER) begin
            opa_q <= opa_shift;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter) begin
                result   <= iter_result;
                cout     <= 1'b0;
                overflow <= 1'b0;
                zero     <= (iter_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

    localparam int WIDTH = 32;
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  signal = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        cout, overflow, zero, busy;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        int          lat;
        bit          zknown;
    } exp_t;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .signal    (signal),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] sh);
        exp_t        e;
        longint      sx, sy, s;
        logic [63:0] wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.zknown = 1'b1;
        case (op)
            3'b000: e.r = x & y;
            3'b001: e.r = x | y;
            3'b010, 3'b100: begin
                wide = {32'b0, x} + {32'b0, y};
                e.r  = wide[31:0];
                e.c  = wide[32];
                s    = sx + sy;
                e.v  = (op == 3'b010) && ((s > MAX_S) || (s < MIN_S));
            end
            3'b011: begin
                e.r   = x >> sh;
                e.lat = (sh == 5'd0) ? 1 : int'(sh) + 1;
            end
            3'b101: begin
`ifdef MULTICYCLE_ALU_MUL_EN
                wide  = {32'b0, x} * {32'b0, y};
                e.r   = wide[31:0];
                e.lat = WIDTH + 1;
`else
                e.r      = '0;
                e.zknown = 1'b0;
`endif
            end
            3'b110: begin
                e.r = x - y;
                e.c = (x >= y);
                s   = sx - sy;
                e.v = (s > MAX_S) || (s < MIN_S);
            end
            default: e.r = (sx < sy) ? 32'd1 : 32'd0;
        endcase
        return e;
    endfunction

    // Presents one op, scrambles inputs after accept, waits for out_valid and checks it.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] sh, input string tag);
        exp_t e;
        int   n;
        int   lat;
        bit   bad;
        e = model(op, x, y, sh);
        signal = op; a = x; b = y; shamt = sh; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        step();
        in_valid = 1'b0;
        signal = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) bad = 1'b1;
            step();
            lat++;
        end
        if (e.lat > 1) chk({tag, "_busy"}, 64'(bad), 64'd0);
        chk({tag, "_lat"},    64'(lat),      64'(e.lat));
        chk({tag, "_result"}, 64'(result),   64'(e.r));
        chk({tag, "_cout"},   64'(cout),     64'(e.c));
        chk({tag, "_ovf"},    64'(overflow), 64'(e.v));
        if (e.zknown) chk({tag, "_zero"}, 64'(zero), 64'(e.r == 32'd0));
    endtask

    task automatic drain(input int hold, input string tag);
        logic [31:0] held;
        bit          bad;
        held = result;
        bad  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!out_valid || in_ready || result !== held) bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] specials [5];
        logic [2:0]  op;
        logic [31:0] x, y;
        bit          bad;
        specials[0] = 32'h0;        specials[1] = 32'h1;
        specials[2] = 32'h7FFFFFFF; specials[3] = 32'h80000000;
        specials[4] = 32'hFFFFFFFF;

        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({out_valid, busy, cout, overflow, zero}), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        issue(3'b010, 32'h7FFFFFFF, 32'h1, 5'd0, "add_ovf");  drain(0, "add_ovf");
        issue(3'b110, 32'd5, 32'd5, 5'd0, "sub_eq");           drain(0, "sub_eq");
        issue(3'b111, 32'hFFFFFFFF, 32'h1, 5'd0, "slt_neg");   drain(0, "slt_neg");
        issue(3'b011, 32'h80000000, 32'h0, 5'd31, "srl_31");   drain(0, "srl_31");
        issue(3'b011, 32'hA5A5F00F, 32'h0, 5'd0, "srl_0");     drain(0, "srl_0");
        issue(3'b101, 32'h10001, 32'h10001, 5'd0, "mul");      drain(0, "mul");

        // Held result under backpressure, then handshake and accept in the same cycle.
        issue(3'b001, 32'h1200, 32'h0034, 5'd0, "or_hold");
        signal = 3'b000; a = 32'hF0; b = 32'h3C; in_valid = 1'b1;
        drain_free: begin
            logic [31:0] held;
            held = result;
            bad  = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (!out_valid || in_ready || result !== held) bad = 1'b1;
            end
            chk("bp_hold", 64'(bad), 64'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0; a = $urandom; b = $urandom;
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_result", 64'(result), 64'h30);
        drain(0, "b2b");

        // Reset in the middle of a long operation.
`ifdef MULTICYCLE_ALU_MUL_EN
        signal = 3'b101; shamt = 5'd0;
`else
        signal = 3'b011; shamt = 5'd31;
`endif
        a = 32'h12345678; b = 32'h9ABCDEF1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #1;
        chk("midrst_state", 64'({out_valid, busy}), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        #3 rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        chk("midrst_no_valid", 64'(bad), 64'd0);
        issue(3'b010, 32'd2, 32'd3, 5'd0, "add_after_rst");   drain(0, "add_after_rst");

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            issue(op, x, y, 5'($urandom), "rnd");
            drain($urandom_range(0, 2), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width, minimum 4.
REQ-002 SHALL have localparam SHAMT_W = $clog2(WIDTH): width of the shift-amount field.
REQ-003 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1: an operation is presented.
REQ-006 SHALL have port in_ready  out  1: the block accepts the operation this cycle.
REQ-007 SHALL have port signal  in  3: the opcode. AND=000, OR=001, ADD=010, SRL=011, ADDIU=100, MUL=101, SUB=110, SLT=111.
REQ-008 SHALL have port a  in  WIDTH: operand A.
REQ-009 SHALL have port b  in  WIDTH: operand B.
REQ-010 SHALL have port shamt  in  SHAMT_W: SRL shift amount.
REQ-011 SHALL have port out_valid  out  1: the result is available.
REQ-012 SHALL have port out_ready  in  1: the consumer takes the result.
REQ-013 SHALL have port result  out  WIDTH: the result value.
REQ-014 SHALL have port cout  out  1: carry-out of ADD/ADDIU/SUB; 0 for other opcodes.
REQ-015 SHALL have port overflow  out  1: signed overflow of ADD/SUB; 0 for other opcodes.
REQ-016 SHALL have port zero  out  1: set when result == 0.
REQ-017 SHALL have port busy  out  1: set when the state is ITER.

Function
REQ-018 SHALL implement FSM states IDLE, ITER, DONE.
REQ-019 Accept SHALL occur when in_valid && in_ready; operands and opcode are captured at accept and later input changes have no effect.
REQ-020 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready=1; it SHALL be 0 in ITER.
REQ-021 Single-cycle opcodes (AND, OR, ADD, ADDIU, SUB, SLT) SHALL go from accept to DONE with out_valid=1 on the next cycle (latency 1).
REQ-022 SUB SHALL compute a + ~b + 1; cout is the carry of that sum.
REQ-023 SLT SHALL return {0.., sign(a-b) XOR overflow(a-b)}, a signed compare.
REQ-024 ADDIU SHALL compute a + b with overflow forced to 0.
REQ-025 SRL SHALL be logical, shifting 1 bit per cycle in ITER for shamt cycles; latency is shamt+1, and shamt=0 goes straight to DONE (latency 1).
REQ-026 MUL SHALL use shift-add, 1 bit per cycle, WIDTH cycles in ITER, returning the low WIDTH bits of the unsigned product; latency WIDTH+1.
REQ-027 In DONE, result and flags SHALL hold stable until out_valid && out_ready.
REQ-028 On handshake with no new accept, the FSM SHALL return to IDLE and out_valid SHALL be 0 the next cycle.
REQ-029 A simultaneous out handshake and new accept in DONE SHALL be honoured; the next result follows at that opcode's normal latency, with no bubble beyond that latency.
REQ-030 cout, overflow and zero SHALL be registered together with result.

Reset
REQ-031 On rst=1, the block SHALL immediately enter IDLE with result=0, cout=0, overflow=0, zero=0, out_valid=0 and busy=0; in_ready=1 once rst is released.
REQ-032 A reset asserted during ITER or DONE SHALL discard the operation, with no out_valid pulse afterward.

Configuration
REQ-033 The macro MULTICYCLE_ALU_MUL_EN SHALL control MUL.
REQ-034 With MULTICYCLE_ALU_MUL_EN defined, opcode 101 SHALL perform MUL per REQ-026.
REQ-035 Without MULTICYCLE_ALU_MUL_EN, opcode 101 SHALL be treated as single-cycle, returning result=0 and flags 0 at latency 1, and no multiplier datapath SHALL be synthesised.

Structure
REQ-036 Package alu_pkg SHALL hold the opcode constants and the FSM state typedef.
REQ-037 Sub-module alu_comb_core SHALL hold the combinational logic for the single-cycle opcodes, producing result, cout and overflow.
REQ-038 The FSM, the SRL/MUL iteration counter and the output registers SHALL live in multicycle_alu.

Verification
REQ-039 ADD a=0x7FFFFFFF, b=1 -> 1 cycle later result=0x80000000, overflow=1, cout=0, zero=0.
REQ-040 SUB a=5, b=5 -> result=0, zero=1, cout=1; then SLT a=0xFFFFFFFF (-1), b=1 -> result=1.
REQ-041 SRL a=0x80000000, shamt=31 -> busy for 31 cycles, in_ready=0 throughout, result=1 on cycle 32; with shamt=0 -> result=a after 1 cycle.
REQ-042 With MULTICYCLE_ALU_MUL_EN defined: MUL a=0x10001, b=0x10001 -> result=0x00020001 after 33 cycles. Without it: result=0 after 1 cycle.
REQ-043 Hold out_ready=0 for 5 cycles in DONE -> result stable, no accept; then out_ready=1 with in_valid=1 (AND 0xF0, 0x3C) -> back-to-back handshake, next result 0x30.
REQ-044 Assert rst mid-way through a MUL -> IDLE, out_valid never rises; a following ADD 2+3 -> result=5.
